i2c_slave_mpu_6050: RTL
=======================

// Module: i2c_slave_mpu_6050
// PURPOSE
//  I2C responder that emulates the MPU-6050 register interface. It is the far
//  end of the I2C master path and is used for loopback or bench testing of the
//  master without the sensor. Local logic loads sensor values into a 128-byte
//  register file, and the bus master reads them over SCL/SDA.
//  Open-drain SDA only. No clock stretching (SCL is input only).
// PARAMETERS
//  FPGA_CLK  50_000_000  system clock in Hz; must be >= 16*I2C_CLK
//  I2C_CLK   400_000     maximum bus frequency in Hz
//  DEV_ADDR  7'h68       7-bit slave address (AD0=0)
// PORTS
//  CLK          in   1  system clock
//  RST          in   1  synchronous reset, active-high
//  I_SCL        in   1  bus SCL level (asynchronous)
//  I_SDA        in   1  bus SDA level (asynchronous)
//  O_SDA_OE     out  1  1 = pull SDA low; 0 = release (top level ties SDA to 1'bz)
//  I_REG_WE     in   1  local write strobe into register file
//  I_REG_ADDR   in   7  local write address
//  I_REG_DATA   in   8  local write data
//  O_WR_STB     out  1  1-cycle pulse: master wrote a register
//  O_WR_ADDR    out  7  address of the master write (valid with O_WR_STB)
//  O_WR_DATA    out  8  data of the master write (valid with O_WR_STB)
//  O_BUSY       out  1  1 from START to STOP when this device is addressed
// BEHAVIOUR
//  - Reset: O_SDA_OE=0, O_WR_STB=0, O_WR_ADDR=0, O_WR_DATA=0, O_BUSY=0, FSM=IDLE,
//    reg pointer=0. Regs=0x00 except 0x6B=0x40. 0x75 (WHO_AM_I) is read-only
//    and always reads DEV_ADDR. RST mid-transfer releases SDA within 1 CLK.
//  - Input path: 2-FF synchronizer on SCL and SDA, plus one more stage for edge
//    detection. All decisions use the synchronized levels (3-cycle latency).
//  - START (or repeated START): SDA falls while SCL is high -> ADDR from any state.
//    STOP: SDA rises while SCL is high -> IDLE, O_BUSY=0, SDA released.
//    START/STOP win over any simultaneous data event.
//  - Bits are sampled on the SCL rising edge, MSB first. O_SDA_OE changes only
//    on the sampled SCL falling edge, never while SCL is high.
//  - FSM states:
//    IDLE     -> ADDR on START.
//    ADDR     8 bits; if addr==DEV_ADDR: ADDR_ACK, else IGNORE.
//    ADDR_ACK drive 0 for the 9th clock; O_BUSY=1; R/W=0 -> PTR; R/W=1 -> RD_DATA.
//    PTR      8 bits; pointer <= byte[6:0]; bit7 ignored -> PTR_ACK -> WR_DATA.
//    WR_DATA  8 bits -> WR_ACK: ACK, O_WR_STB pulse, reg write, pointer+1 -> WR_DATA.
//    RD_DATA  reg[pointer] loaded into the shift register at the SCL fall that ends
//             the previous ACK, and stays stable for the whole byte; pointer+1.
//    RD_ACK   release SDA and sample the 9th bit: 0 (ACK) -> RD_DATA;
//             1 (NACK) -> IGNORE.
//    IGNORE   SDA released; wait for START or STOP.
//  - Pointer is 7 bits and wraps 0x7F -> 0x00 on both reads and writes.
//  - A master write to 0x75 is ACKed and strobed, but the register is unchanged.
//  - Local I_REG_WE and a master write to the same address in the same CLK:
//    the local write wins, and O_WR_STB still fires with the master data.
//    Local writes take effect the next CLK; a byte already loaded for reading
//    is not altered.
//  - Register file is 128x8 with one write port (arbitrated as above) and a
//    synchronous read used at byte load.
// TESTING
//  1 Reset, then the master reads 1 byte at 0x75 -> address ACK, data 0x68,
//    master NACK, STOP, O_BUSY=0.
//  2 Master writes ptr 0x1B, then data 0x18, 0x05 -> two O_WR_STB pulses with
//    (0x1B,0x18) and (0x1C,0x05); read-back of 0x1B gives 0x18.
//  3 Local load 0x3B..0x40 = 01..06; master burst-reads 6 bytes from 0x3B with a
//    repeated START -> 01..06, ACK on the first 5 bytes, NACK on the last.
//  4 Master addresses 0x69 -> SDA never driven, no strobe, O_BUSY stays 0;
//    the next transfer to 0x68 succeeds.
//  5 Master reads 2 bytes from 0x7F -> returns reg[0x7F], then reg[0x00].
//  6 RST asserted during RD_DATA while driving 0 -> O_SDA_OE=0 the next CLK;
//    0x6B reads 0x40 afterwards.

Source files
------------

// File: rtl/i2c_slave_mpu_6050_if.sv
// Bus and local-port bundle for the MPU-6050 I2C responder.
// The slave modport is the responder's view; the master modport is the view
// of whatever drives the bus lines and the local register port.
interface i2c_slave_mpu_6050_if;
    logic       I_SCL;
    logic       I_SDA;
    logic       O_SDA_OE;
    logic       I_REG_WE;
    logic [6:0] I_REG_ADDR;
    logic [7:0] I_REG_DATA;
    logic       O_WR_STB;
    logic [6:0] O_WR_ADDR;
    logic [7:0] O_WR_DATA;
    logic       O_BUSY;

    modport slave (
        input  I_SCL, I_SDA, I_REG_WE, I_REG_ADDR, I_REG_DATA,
        output O_SDA_OE, O_WR_STB, O_WR_ADDR, O_WR_DATA, O_BUSY
    );

    modport master (
        output I_SCL, I_SDA, I_REG_WE, I_REG_ADDR, I_REG_DATA,
        input  O_SDA_OE, O_WR_STB, O_WR_ADDR, O_WR_DATA, O_BUSY
    );
endinterface

// File: rtl/i2c_slave_mpu_6050.sv
// I2C responder emulating the MPU-6050 register map (128 x 8 bytes).
// SCL/SDA are oversampled by CLK; SDA is open-drain via O_SDA_OE.
// WHO_AM_I (0x75) is read-only and always returns DEV_ADDR.
module i2c_slave_mpu_6050 #(
    parameter int unsigned FPGA_CLK = 50_000_000,
    parameter int unsigned I2C_CLK  = 400_000,
    parameter logic [6:0]  DEV_ADDR = 7'h68
) (
    input  logic                    CLK,
    input  logic                    RST,
    i2c_slave_mpu_6050_if.slave     bus
);
    localparam logic [6:0] WHO_AM_I = 7'h75;

    if (FPGA_CLK < 16 * I2C_CLK) begin : g_clk_ratio_bad
        $error("FPGA_CLK must be at least 16x I2C_CLK");
    end

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q, sda_sync_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] ack_ph_q, ack_ph_d;
    logic [6:0] sr_q, sr_d;
    logic [6:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rd_q, rd_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_stb_q, wr_stb_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] mem_q [128];

    logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] rx_byte_s;
    logic       mwe_s, mem_we_s;
    logic [6:0] mem_waddr_s;
    logic [7:0] mem_wdata_s;

    // Decisions use stage 2; stage 3 is the previous level for edge detection.
    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise_s = scl_s & ~scl_sync_q[2];
    assign scl_fall_s = ~scl_s & scl_sync_q[2];
    assign start_s    = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
    assign stop_s     = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;
    assign rx_byte_s  = {sr_q, sda_s};

    assign bus.O_SDA_OE  = sda_oe_q;
    assign bus.O_BUSY    = busy_q;
    assign bus.O_WR_STB  = wr_stb_q;
    assign bus.O_WR_ADDR = wr_addr_q;
    assign bus.O_WR_DATA = wr_data_q;

    // Bus synchronizers, FSM and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            ack_ph_q   <= 2'd0;
            sr_q       <= 7'd0;
            ptr_q      <= 7'd0;
            rw_q       <= 1'b0;
            tx_q       <= 8'd0;
            rd_q       <= 8'd0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 8'd0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], bus.I_SCL};
            sda_sync_q <= {sda_sync_q[1:0], bus.I_SDA};
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_ph_q   <= ack_ph_d;
            sr_q       <= sr_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            tx_q       <= tx_d;
            rd_q       <= rd_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register file: reset image, then a single arbitrated write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 128; i++) begin
                mem_q[i] <= 8'h00;
            end
            mem_q[7'h6B] <= 8'h40;
        end else if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end else begin
            mem_q[mem_waddr_s] <= mem_q[mem_waddr_s];
        end
    end

    // Next-state logic: bit sampling on SCL rise, SDA updates on SCL fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ack_ph_d    = ack_ph_q;
        sr_d        = sr_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        tx_d        = tx_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mwe_s       = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = ptr_q;
        mem_wdata_s = rx_byte_s;
        rd_d        = (ptr_q == WHO_AM_I) ? {1'b0, DEV_ADDR} : mem_q[ptr_q];

        case (state_q)
            IDLE: begin
                sda_oe_d = 1'b0;
            end
            ADDR, PTR, WR_DATA: begin
                if (scl_rise_s) begin
                    sr_d      = rx_byte_s[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    ack_ph_d  = 2'd0;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ADDR) begin
                            rw_d = rx_byte_s[0];
                            if (rx_byte_s[7:1] == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d   = rx_byte_s[6:0];
                            state_d = PTR_ACK;
                        end else begin
                            mwe_s     = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte_s;
                            ptr_d     = ptr_q + 7'd1;
                            state_d   = WR_ACK;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ADDR_ACK, PTR_ACK, WR_ACK: begin
                // Phase 0: the fall ending bit 8 starts the ACK.
                // Phase 1: the fall ending the 9th clock finishes it.
                if (scl_fall_s) begin
                    if (ack_ph_q == 2'd0) begin
                        sda_oe_d = 1'b1;
                        ack_ph_d = 2'd1;
                    end else if (state_q == ADDR_ACK && rw_q) begin
                        tx_d      = rd_q;
                        sda_oe_d  = ~rd_q[7];
                        ptr_d     = ptr_q + 7'd1;
                        bit_cnt_d = 3'd0;
                        state_d   = RD_DATA;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = (state_q == ADDR_ACK) ? PTR : WR_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RD_DATA: begin
                if (scl_rise_s) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    ack_ph_d  = 2'd0;
                    state_d   = (bit_cnt_q == 3'd7) ? RD_ACK : RD_DATA;
                end else if (scl_fall_s && bit_cnt_q != 3'd0) begin
                    sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
                end else begin
                    state_d = state_q;
                end
            end
            RD_ACK: begin
                if (scl_fall_s && ack_ph_q == 2'd0) begin
                    sda_oe_d = 1'b0;
                    ack_ph_d = 2'd1;
                end else if (scl_rise_s && ack_ph_q == 2'd1) begin
                    if (sda_s) begin
                        state_d = IGNORE;
                    end else begin
                        ack_ph_d = 2'd2;
                    end
                end else if (scl_fall_s && ack_ph_q == 2'd2) begin
                    tx_d      = rd_q;
                    sda_oe_d  = ~rd_q[7];
                    ptr_d     = ptr_q + 7'd1;
                    bit_cnt_d = 3'd0;
                    state_d   = RD_DATA;
                end else begin
                    state_d = state_q;
                end
            end
            IGNORE: begin
                sda_oe_d = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                sda_oe_d = 1'b0;
            end
        endcase

        // Bus conditions override any data-phase decision.
        if (stop_s) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else if (start_s) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            state_d = state_d;
        end

        // Local port owns the write port when both request in one cycle.
        if (bus.I_REG_WE) begin
            mem_we_s    = (bus.I_REG_ADDR != WHO_AM_I);
            mem_waddr_s = bus.I_REG_ADDR;
            mem_wdata_s = bus.I_REG_DATA;
        end else if (mwe_s) begin
            mem_we_s    = (ptr_q != WHO_AM_I);
            mem_waddr_s = ptr_q;
            mem_wdata_s = rx_byte_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end
endmodule
